// File: rtl/call_stack_ctrl.sv
// Hardware return-address stack: push on CALL, pop on RET, swap on both.
// A pop or swap loads pc_target and pulses pc_load for one cycle.
// overflow and underflow are sticky until err_clr.
module call_stack_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     call,
    input  logic                     ret,
    input  logic [WIDTH-1:0]         return_address,
    input  logic                     err_clr,
    output logic                     pc_load,
    output logic [WIDTH-1:0]         pc_target,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_SWAP,
        OP_OVF,
        OP_UNF,
        OP_PUSH_UNF
    } op_t;

    logic [SP_W-1:0]  r_sp;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_pc_load;
    logic [WIDTH-1:0] r_pc_target;
    logic             r_overflow;
    logic             r_underflow;

    op_t              w_op;
    logic             w_empty;
    logic             w_full;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_idx;
    logic [SP_W-1:0]  w_sp_nxt;
    logic             w_pc_load_nxt;
    logic [WIDTH-1:0] w_pc_target_nxt;
    logic             w_ovf_set;
    logic             w_unf_set;

    // Occupancy status straight from the stack pointer.
    always_comb begin
        w_empty   = (r_sp == '0);
        w_full    = (r_sp == SP_W'(DEPTH));
        w_wr_idx  = r_sp[IDX_W-1:0];
        w_top_idx = IDX_W'(r_sp - SP_W'(1));
    end

    // Classify the request against the current occupancy.
    always_comb begin
        w_op = OP_IDLE;
        if (call && !ret) begin
            w_op = w_full ? OP_OVF : OP_PUSH;
        end else if (ret && !call) begin
            w_op = w_empty ? OP_UNF : OP_POP;
        end else if (call && ret) begin
            w_op = w_empty ? OP_PUSH_UNF : OP_SWAP;
        end
    end

    // Next-state values for pointer, memory write port, outputs and flags.
    always_comb begin
        w_sp_nxt        = r_sp;
        w_mem_we        = 1'b0;
        w_mem_idx       = w_wr_idx;
        w_pc_load_nxt   = 1'b0;
        w_pc_target_nxt = r_pc_target;
        w_ovf_set       = 1'b0;
        w_unf_set       = 1'b0;
        case (w_op)
            OP_PUSH: begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_wr_idx;
                w_sp_nxt  = r_sp + SP_W'(1);
            end
            OP_PUSH_UNF: begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_wr_idx;
                w_sp_nxt  = r_sp + SP_W'(1);
                w_unf_set = 1'b1;
            end
            OP_POP: begin
                w_sp_nxt        = r_sp - SP_W'(1);
                w_pc_load_nxt   = 1'b1;
                w_pc_target_nxt = r_mem[w_top_idx];
            end
            OP_SWAP: begin
                w_mem_we        = 1'b1;
                w_mem_idx       = w_top_idx;
                w_pc_load_nxt   = 1'b1;
                w_pc_target_nxt = r_mem[w_top_idx];
            end
            OP_OVF:  w_ovf_set = 1'b1;
            OP_UNF:  w_unf_set = 1'b1;
            default: ;
        endcase
    end

    // Control state; reset discards the stack and any pending load strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp        <= '0;
            r_pc_load   <= 1'b0;
            r_pc_target <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_pc_load   <= w_pc_load_nxt;
            r_pc_target <= w_pc_target_nxt;
            r_overflow  <= (r_overflow  & ~err_clr) | w_ovf_set;
            r_underflow <= (r_underflow & ~err_clr) | w_unf_set;
        end
    end

    // Entry storage, left unreset since contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= return_address;
        end
    end

    assign pc_load   = r_pc_load;
    assign pc_target = r_pc_target;
    assign depth     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: doc/call_stack_ctrl.md
CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of return-address entries (power of two, 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, return-address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port call, input, 1 bit: push request, from the CALL decode strobe.
REQ-006 SHALL have port ret, input, 1 bit: pop request, from the RET decode strobe.
REQ-007 SHALL have port return_address, input, WIDTH bits: value pushed on call, already counter+4 from the decoder.
REQ-008 SHALL have port err_clr, input, 1 bit: clears sticky error flags.
REQ-009 SHALL have port pc_load, output, 1 bit: one-cycle strobe telling the program counter to load pc_target.
REQ-010 SHALL have port pc_target, output, WIDTH bits: popped return address.
REQ-011 SHALL have port depth, output, $clog2(DEPTH)+1 bits: current number of valid entries.
REQ-012 SHALL have port empty, output, 1 bit: depth==0.
REQ-013 SHALL have port full, output, 1 bit: depth==DEPTH.
REQ-014 SHALL have port overflow, output, 1 bit: sticky push-when-full flag.
REQ-015 SHALL have port underflow, output, 1 bit: sticky pop-when-empty flag.

Function
REQ-016 SHALL implement a LIFO of DEPTH entries with a stack pointer sp equal to depth; the top entry is mem[sp-1].
REQ-017 SHALL treat the operation as PUSH when call=1 and ret=0 and not full: mem[sp]<=return_address, sp<=sp+1.
REQ-018 SHALL treat the operation as POP when ret=1 and call=0 and not empty: sp<=sp-1, pc_target<=mem[sp-1], pc_load<=1 in the next cycle.
REQ-019 SHALL give POP a latency of exactly one cycle: ret sampled at edge N, pc_load high for the single cycle after edge N, with pc_target valid in that cycle.
REQ-020 SHALL drive pc_load=0 in every cycle that does not follow a successful POP or SWAP; pc_target SHALL hold its last value otherwise.
REQ-021 SHALL treat call=1 and ret=1 with not empty as SWAP: pc_target<=mem[sp-1], pc_load<=1, mem[sp-1]<=return_address, sp unchanged.
REQ-022 SHALL treat call=1 and ret=1 with empty as PUSH only, and set underflow.
REQ-023 SHALL, on call=1 and ret=0 while full, discard the push, leave sp and mem unchanged, and set overflow.
REQ-024 SHALL, on ret=1 and call=0 while empty, leave pc_load=0, leave pc_target unchanged, and set underflow.
REQ-025 SHALL keep overflow and underflow set until err_clr=1; if err_clr and a new error occur in the same cycle, the flag SHALL end up set.
REQ-026 SHALL derive empty, full and depth combinationally from sp, with no added latency.
REQ-027 SHALL never wrap sp: sp SHALL stay within 0..DEPTH under all input sequences.
REQ-028 SHALL ignore return_address except during PUSH and SWAP.

Reset
REQ-029 SHALL, while rst=0, force sp=0, pc_load=0, pc_target=0, overflow=0 and underflow=0 immediately, independent of clk.
REQ-030 SHALL leave entry contents undefined after reset; a reset in the middle of an operation SHALL discard the stack and any pending pc_load.
REQ-031 SHALL resume normal operation on the first rising clk edge after rst returns high.

Verification
REQ-032 Push/pop order: call with return_address=0x10, then 0x20, then 0x30, then ret x3 -> pc_target 0x30, 0x20, 0x10, each with a one-cycle pc_load one cycle after its ret; empty=1 at the end.
REQ-033 Overflow: with DEPTH=8, do 9 calls with 0x01..0x09 -> full=1, depth=8, overflow=1; then 8 rets -> pc_target 0x08 down to 0x01; then err_clr -> overflow=0.
REQ-034 Underflow: ret while empty -> pc_load=0, pc_target unchanged, underflow=1, depth=0.
REQ-035 Swap: with stack [0x10,0x20], assert call and ret together with return_address=0x44 -> pc_load=1, pc_target=0x20, depth=2; then ret -> pc_target=0x44.
REQ-036 Async reset: push 3 entries, drop rst mid-cycle while ret=1 -> depth=0, pc_load=0 immediately, with no pc_load pulse after rst releases.
